// File: rtl/serializer_pkg.sv
// Shared types and helpers for the MSB-first parallel-to-serial converter.
// Optional even-parity trailer cycle is enabled with SERIALIZER_PARITY_EN.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned MIN_MOD = 3;

  // Number of bits to send; 0 marks a rejected word (mod 1 or 2).
  function automatic int unsigned calc_n(input int unsigned mod_v, input int unsigned w);
    if (mod_v == 0)
      return w;
    else if (mod_v < MIN_MOD)
      return 0;
    else
      return mod_v;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts N bits of a word out MSB-first with a valid strobe.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module serializer
  import serializer_pkg::*;
#(
  parameter int W     = 16,
  parameter int MOD_W = $clog2(W)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [W-1:0]     data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  // Counter must hold N=W, one bit wider than the mod field.
  localparam int CNT_W = MOD_W + 1;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ser_data, w_ser_data_nxt;
  logic             r_ser_val, w_ser_val_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] w_n;
  logic             w_accept;
`ifdef SERIALIZER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_n      = CNT_W'(calc_n(32'(data_mod_i), W));
  assign w_accept = data_val_i && (w_n != '0);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ser_data <= w_ser_data_nxt;
      r_ser_val  <= w_ser_val_nxt;
      r_busy     <= w_busy_nxt;
`ifdef SERIALIZER_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  // Next-state and next-output logic; the bit driven next cycle is chosen here
  // so every output leaves a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_ser_data_nxt = 1'b0;
    w_ser_val_nxt  = 1'b0;
    w_busy_nxt     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt    = SEND;
          w_shift_nxt    = data_i << 1;
          w_cnt_nxt      = w_n;
          w_ser_data_nxt = data_i[W-1];
          w_ser_val_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          w_par_nxt      = data_i[W-1];
`endif
        end
      end
      SEND: begin
        if (r_cnt > CNT_W'(1)) begin
          w_shift_nxt    = r_shift << 1;
          w_cnt_nxt      = r_cnt - CNT_W'(1);
          w_ser_data_nxt = r_shift[W-1];
          w_ser_val_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          w_par_nxt      = r_par ^ r_shift[W-1];
`endif
        end else begin
          w_cnt_nxt = '0;
`ifdef SERIALIZER_PARITY_EN
          w_state_nxt    = PARITY;
          w_ser_data_nxt = r_par;
          w_ser_val_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
`else
          w_state_nxt    = IDLE;
`endif
        end
      end
      PARITY:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ser_data_o     = r_ser_data;
  assign ser_data_val_o = r_ser_val;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer: timing, rejection, back-pressure, reset abort, loopback.
// Parity expectations follow SERIALIZER_PARITY_EN when it is defined.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o, ser_data_val_o, busy_o;

  int total = 0;
  int bad   = 0;

  logic cap_d [0:40];
  logic cap_v [0:40];
  logic cap_b [0:40];

  serializer #(.W(16)) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one cycle; returns at the sample point of cycle t+1.
  task automatic drive_word(input logic [15:0] d, input logic [3:0] m);
    data_i     = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_d[i] = ser_data_o;
      cap_v[i] = ser_data_val_o;
      cap_b[i] = busy_o;
      tick();
    end
  endtask

  task automatic test_reset();
    srst_i     = 1'b1;
    data_i     = 16'hFFFF;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    tick();
    tick();
    total++;
    if (ser_data_o !== 1'b0) begin bad++; $display("FAIL reset_data got=%b exp=0", ser_data_o); end
    total++;
    if (ser_data_val_o !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", ser_data_val_o); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    data_val_i = 1'b0;
    srst_i     = 1'b0;
    tick();
    total++;
    if ({busy_o, ser_data_val_o, ser_data_o} !== 3'b000) begin
      bad++; $display("FAIL reset_release got=%b exp=000", {busy_o, ser_data_val_o, ser_data_o});
    end
  endtask

  task automatic test_full_word();
    logic [15:0] w;
    w = 16'hA5C3;
    drive_word(w, 4'd0);
    capture(18 + PAR);
    for (int k = 0; k < 16; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== {2'b11, w[15-k]}) begin
        bad++; $display("FAIL full_bit%0d got=%b exp=%b", k, {cap_b[k], cap_v[k], cap_d[k]}, {2'b11, w[15-k]});
      end
    end
    total++;
    if ({cap_b[16+PAR], cap_v[16+PAR], cap_d[16+PAR]} !== 3'b000) begin
      bad++; $display("FAIL full_end got=%b exp=000", {cap_b[16+PAR], cap_v[16+PAR], cap_d[16+PAR]});
    end
  endtask

  task automatic test_short_word();
    drive_word(16'hF000, 4'd4);
    capture(8);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== 3'b111) begin
        bad++; $display("FAIL short_bit%0d got=%b exp=111", k, {cap_b[k], cap_v[k], cap_d[k]});
      end
    end
    for (int k = 4 + PAR; k < 8; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== 3'b000) begin
        bad++; $display("FAIL short_idle%0d got=%b exp=000", k, {cap_b[k], cap_v[k], cap_d[k]});
      end
    end
  endtask

  task automatic test_reject();
    logic [15:0] w;
    for (int m = 1; m <= 2; m++) begin
      drive_word(16'hFFFF, 4'(m));
      capture(3);
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({cap_b[k], cap_v[k], cap_d[k]} !== 3'b000) begin
          bad++; $display("FAIL reject_mod%0d_c%0d got=%b exp=000", m, k, {cap_b[k], cap_v[k], cap_d[k]});
        end
      end
    end
    w = 16'hB800;
    drive_word(w, 4'd5);
    capture(6 + PAR);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== {2'b11, w[15-k]}) begin
        bad++; $display("FAIL after_reject_bit%0d got=%b exp=%b", k, {cap_b[k], cap_v[k], cap_d[k]}, {2'b11, w[15-k]});
      end
    end
    total++;
    if ({cap_b[5+PAR], cap_v[5+PAR]} !== 2'b00) begin
      bad++; $display("FAIL after_reject_end got=%b exp=00", {cap_b[5+PAR], cap_v[5+PAR]});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2;
    w1 = 16'hC3A5;
    w2 = 16'h1234;
    drive_word(w1, 4'd0);
    // Offer a second word on every busy cycle, with a changing payload and mod.
    for (int k = 0; k < 16 + PAR; k++) begin
      if (k < 16) begin
        total++;
        if ({busy_o, ser_data_val_o, ser_data_o} !== {2'b11, w1[15-k]}) begin
          bad++; $display("FAIL b2b_first_bit%0d got=%b exp=%b", k, {busy_o, ser_data_val_o, ser_data_o}, {2'b11, w1[15-k]});
        end
      end
      data_i     = w2 ^ 16'(k);
      data_mod_i = 4'd3;
      data_val_i = 1'b1;
      tick();
    end
    total++;
    if ({busy_o, ser_data_val_o, ser_data_o} !== 3'b000) begin
      bad++; $display("FAIL b2b_gap got=%b exp=000", {busy_o, ser_data_val_o, ser_data_o});
    end
    drive_word(w2, 4'd0);
    capture(17 + PAR);
    for (int k = 0; k < 16; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== {2'b11, w2[15-k]}) begin
        bad++; $display("FAIL b2b_second_bit%0d got=%b exp=%b", k, {cap_b[k], cap_v[k], cap_d[k]}, {2'b11, w2[15-k]});
      end
    end
    total++;
    if ({cap_b[16+PAR], cap_v[16+PAR]} !== 2'b00) begin
      bad++; $display("FAIL b2b_second_end got=%b exp=00", {cap_b[16+PAR], cap_v[16+PAR]});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    drive_word(16'hFFFF, 4'd0);
    capture(4);
    total++;
    if ({busy_o, ser_data_val_o, ser_data_o} !== 3'b111) begin
      bad++; $display("FAIL midrst_bit5 got=%b exp=111", {busy_o, ser_data_val_o, ser_data_o});
    end
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    total++;
    if ({busy_o, ser_data_val_o, ser_data_o} !== 3'b000) begin
      bad++; $display("FAIL midrst_abort got=%b exp=000", {busy_o, ser_data_val_o, ser_data_o});
    end
    tick();
    total++;
    if ({busy_o, ser_data_val_o, ser_data_o} !== 3'b000) begin
      bad++; $display("FAIL midrst_no_resume got=%b exp=000", {busy_o, ser_data_val_o, ser_data_o});
    end
    w = 16'h0001;
    drive_word(w, 4'd0);
    capture(17 + PAR);
    for (int k = 0; k < 16; k++) begin
      total++;
      if ({cap_b[k], cap_v[k], cap_d[k]} !== {2'b11, w[15-k]}) begin
        bad++; $display("FAIL midrst_next_bit%0d got=%b exp=%b", k, {cap_b[k], cap_v[k], cap_d[k]}, {2'b11, w[15-k]});
      end
    end
  endtask

  task automatic test_loopback();
    logic [15:0] w, rx;
    int nbits;
    for (int n = 0; n < 1000; n++) begin
      w     = 16'($urandom);
      rx    = '0;
      nbits = 0;
      drive_word(w, 4'd0);
      for (int c = 0; c < 17 + PAR; c++) begin
        if (ser_data_val_o === 1'b1) begin
          if (nbits < 16) rx = {rx[14:0], ser_data_o};
          nbits++;
        end
        tick();
      end
      total++;
      if (rx !== w || nbits != 16 + PAR) begin
        bad++; $display("FAIL loopback%0d got=%h/%0d exp=%h/%0d", n, rx, nbits, w, 16 + PAR);
      end
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    drive_word(16'h0007, 4'd0);
    capture(18);
    total++;
    if ({cap_b[16], cap_v[16], cap_d[16]} !== 3'b111) begin
      bad++; $display("FAIL parity_full got=%b exp=111", {cap_b[16], cap_v[16], cap_d[16]});
    end
    total++;
    if ({cap_b[17], cap_v[17]} !== 2'b00) begin
      bad++; $display("FAIL parity_full_end got=%b exp=00", {cap_b[17], cap_v[17]});
    end
    drive_word(16'hF000, 4'd4);
    capture(6);
    total++;
    if ({cap_b[4], cap_v[4], cap_d[4]} !== 3'b110) begin
      bad++; $display("FAIL parity_short got=%b exp=110", {cap_b[4], cap_v[4], cap_d[4]});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
